uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000: input clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600: serial bit rate.
REQ-003 Parameter OS, default 16: oversampling ticks per bit; must be 16 in this revision.
REQ-004 clk  input  1  sole clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 rx  input  1  asynchronous serial line; idle high; 8N1, LSB first.
REQ-007 data  output  8  last correctly framed byte.
REQ-008 valid  output  1  one-clk pulse when data is updated.
REQ-009 frame_err  output  1  one-clk pulse when the stop bit is sampled low.
REQ-010 busy  output  1  high in any state other than IDLE.

Function
REQ-011 rx shall pass through a 2-FF synchronizer, with both stages reset to 1; all decisions use the synchronized value (rxs).
REQ-012 Oversample tick: a free-running divider of OS_DIV = CLK_HZ/(BAUD*OS) (integer, truncated) shall pulse for 1 clk every OS_DIV clks; its counter is 32 bits and wraps at OS_DIV-1.
REQ-013 States: IDLE, START, DATA, STOP, BREAK; all transitions occur only on tick cycles, except reset.
REQ-014 IDLE: on a tick with rxs=0, clear os_cnt (4 bits) and go to START.
REQ-015 START: on each tick, os_cnt increments; at os_cnt==7 (mid-bit), if rxs=0, clear os_cnt and bit_idx and go to DATA; otherwise treat it as a glitch and go to IDLE with no output pulse.
REQ-016 DATA: on each tick, os_cnt increments; at os_cnt==15, shift rxs into the MSB of the shift register (right shift), clear os_cnt and increment bit_idx (3 bits). Once bit 7 is taken, go to STOP.
REQ-017 STOP: at os_cnt==15, if rxs=1, set data to the shift register, pulse valid and go to IDLE; if rxs=0, pulse frame_err, leave data unchanged and go to BREAK.
REQ-018 BREAK: stay until a tick with rxs=1, then go to IDLE; no start is detected while in BREAK.
REQ-019 Latency: valid asserts about 9.5 bit periods after the start edge (mid-stop sample) plus 2 clks of synchronizer delay.
REQ-020 valid and frame_err shall never be high in the same cycle; neither shall be high for more than 1 clk.
REQ-021 data shall hold its value until the next valid; there is no consumer handshake, and a missed byte is overwritten.
REQ-022 Back-to-back frames: a start bit immediately after a good stop shall be detected; IDLE is entered on the mid-stop tick.

Reset
REQ-023 rst shall force state=IDLE, os_cnt=0, bit_idx=0, shift=0, divider=0, data=8'h00, valid=0, frame_err=0, busy=0, and both synchronizer stages=1.
REQ-024 rst asserted mid-frame shall abort the frame with no valid or frame_err pulse; after release, reception starts afresh from IDLE.

Structure
REQ-025 Package uart_pkg shall hold the rx state enum, the frame constants (DATA_BITS=8, OS=16, MID_START=7, LAST_OS=15) and a function computing OS_DIV.
REQ-026 The tick divider shall be a separate sub-module, uart_os_tick (parameters CLK_HZ, BAUD, OS; ports clk, rst, tick); uart_rx instantiates it once.

Verification
Bench parameters are CLK_HZ=614_400 and BAUD=9600, giving OS_DIV=4 and 64 clk/bit.
REQ-027 Send 0xA5 at 64 clk/bit -> exactly one valid pulse with data=8'hA5, frame_err never high, busy drops after the mid-stop tick.
REQ-028 Drive rx low for 12 clks (3 ticks), then high -> no valid, no frame_err; busy high for at most 8 ticks and then low.
REQ-029 Send 0x3C with the stop bit low, then hold rx low for 200 clks, then high -> one frame_err pulse; data keeps its previous value; busy stays high until rx is seen high; no spurious start.
REQ-030 Send back-to-back 0x00 then 0xFF with no idle gap -> two valid pulses with data 8'h00 then 8'hFF.
REQ-031 Assert rst for 1 clk during bit 4 of 0x55, then send 0x81 -> no pulse for the aborted frame; one valid with data=8'h81.
REQ-032 Send 0x5A with the baud 2% fast (63 clk/bit) -> data=8'h5A, valid once.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and frame constants for the UART receiver.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int OS        = 16;

  localparam logic [3:0] MID_START = 4'd7;
  localparam logic [3:0] LAST_OS   = 4'd15;
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } rx_state_e;

  // Clocks per oversample tick, truncated toward zero.
  function automatic int unsigned os_div(input int unsigned clk_hz,
                                         input int unsigned baud,
                                         input int unsigned os);
    return clk_hz / (baud * os);
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Free-running oversample strobe: one-clk pulse every OS_DIV clocks.
module uart_os_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD   = 9600,
  parameter int unsigned OS     = 16
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned OS_DIV = os_div(CLK_HZ, BAUD, OS);
  localparam logic [31:0] WRAP   = 32'(OS_DIV - 1);

  logic [31:0] cnt_q, cnt_d;

  assign tick = (cnt_q == WRAP);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, 16x oversampled, with framing-error and break handling.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD   = 9600,
  parameter int unsigned OS     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  logic tick;

  uart_os_tick #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OS(OS)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Both stages reset high so a reset never looks like a start edge.
  logic rx_meta_q, rxs_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
    end
  end

  rx_state_e            state_q, state_d;
  logic [3:0]           os_cnt_q, os_cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;

  always_comb begin
    state_d   = state_q;
    os_cnt_d  = os_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    if (tick) begin
      unique case (state_q)
        S_IDLE: begin
          if (!rxs_q) begin
            os_cnt_d = '0;
            state_d  = S_START;
          end
        end
        S_START: begin
          if (os_cnt_q == MID_START) begin
            if (!rxs_q) begin
              os_cnt_d  = '0;
              bit_idx_d = '0;
              state_d   = S_DATA;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            os_cnt_d = os_cnt_q + 4'd1;
          end
        end
        S_DATA: begin
          // LSB arrives first, so shift right and fill from the top.
          if (os_cnt_q == LAST_OS) begin
            shift_d   = {rxs_q, shift_q[DATA_BITS-1:1]};
            os_cnt_d  = '0;
            bit_idx_d = bit_idx_q + 3'd1;
            if (bit_idx_q == LAST_BIT) state_d = S_STOP;
          end else begin
            os_cnt_d = os_cnt_q + 4'd1;
          end
        end
        S_STOP: begin
          // Leaving on the mid-stop tick lets a back-to-back start be caught.
          if (os_cnt_q == LAST_OS) begin
            if (rxs_q) begin
              data_d  = shift_q;
              valid_d = 1'b1;
              state_d = S_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = S_BREAK;
            end
          end else begin
            os_cnt_d = os_cnt_q + 4'd1;
          end
        end
        S_BREAK: begin
          if (rxs_q) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      os_cnt_q  <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      os_cnt_q  <= os_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized frames for uart_rx against a frame-level model.
module tb_uart_rx;

  localparam int CLK_HZ = 614_400;
  localparam int BAUD   = 9600;
  localparam int BIT    = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       valid, frame_err, busy;

  uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OS(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Event monitor: counts pulses and records accepted bytes.
  int         nvalid = 0, nferr = 0, overlap = 0, wide = 0, busy_total = 0, last_vcyc = 0;
  logic       pv = 1'b0, pf = 1'b0;
  logic [7:0] vq[$];

  always @(negedge clk) begin
    if (valid) begin
      vq.push_back(data);
      nvalid++;
      last_vcyc = cyc;
    end
    if (frame_err) nferr++;
    if (valid && frame_err) overlap++;
    if (valid && pv) wide++;
    if (frame_err && pf) wide++;
    if (busy) busy_total++;
    pv = valid;
    pf = frame_err;
  end

  int checks = 0, passes = 0, fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int start_cyc;

  // Drives one frame; the line is left at the stop level on return.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int bclk);
    start_cyc = cyc;
    rx = 1'b0;
    repeat (bclk) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (bclk) @(negedge clk);
    end
    rx = stop;
    repeat (bclk) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  logic [7:0] exp_data;
  logic [7:0] rb;
  logic       rstop;
  int         rbclk, v0, f0, b0, n0, lat;

  initial begin
    exp_data = 8'h00;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_data", 32'(data), 32'h00);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    idle(2 * BIT);

    // Single good frame, with latency window around 9.5 bits + sync delay.
    v0 = nvalid; f0 = nferr;
    send_frame(8'hA5, 1'b1, BIT);
    idle(BIT);
    exp_data = 8'hA5;
    lat = last_vcyc - start_cyc;
    check("a5_valid_cnt", 32'(nvalid - v0), 32'd1);
    check("a5_data", 32'(data), 32'(exp_data));
    check("a5_ferr_cnt", 32'(nferr - f0), 32'd0);
    check("a5_busy_low", 32'(busy), 32'h0);
    check("a5_latency", 32'((lat >= 608) && (lat <= 616)), 32'd1);

    // Short low glitch rejected at mid-start.
    v0 = nvalid; f0 = nferr; b0 = busy_total;
    rx = 1'b0;
    repeat (12) @(negedge clk);
    idle(30 * 4);
    check("glitch_valid", 32'(nvalid - v0), 32'd0);
    check("glitch_ferr", 32'(nferr - f0), 32'd0);
    check("glitch_busy_len", 32'((busy_total - b0 > 0) && (busy_total - b0 <= 32)), 32'd1);
    check("glitch_busy_low", 32'(busy), 32'h0);

    // Bad stop bit followed by a held-low break.
    v0 = nvalid; f0 = nferr;
    send_frame(8'h3C, 1'b0, BIT);
    repeat (200) @(negedge clk);
    check("brk_busy_high", 32'(busy), 32'h1);
    check("brk_ferr_cnt", 32'(nferr - f0), 32'd1);
    check("brk_valid_cnt", 32'(nvalid - v0), 32'd0);
    check("brk_data_kept", 32'(data), 32'(exp_data));
    idle(16);
    b0 = busy_total;
    idle(2 * BIT);
    check("brk_no_restart", 32'(busy_total - b0), 32'd0);
    check("brk_busy_low", 32'(busy), 32'h0);

    // Back-to-back frames with no idle gap.
    n0 = vq.size();
    send_frame(8'h00, 1'b1, BIT);
    send_frame(8'hFF, 1'b1, BIT);
    idle(BIT);
    exp_data = 8'hFF;
    check("b2b_count", 32'(vq.size() - n0), 32'd2);
    if (vq.size() >= n0 + 2) begin
      check("b2b_first", 32'(vq[n0]), 32'h00);
      check("b2b_second", 32'(vq[n0+1]), 32'hFF);
    end
    check("b2b_data", 32'(data), 32'(exp_data));

    // Reset pulse in the middle of bit 4 of 0x55.
    v0 = nvalid; f0 = nferr;
    rb = 8'h55;
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = rb[i];
      repeat (BIT) @(negedge clk);
    end
    rx = rb[4];
    repeat (BIT / 2) @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_data = 8'h00;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_data", 32'(data), 32'(exp_data));
    idle(3 * BIT);
    check("abort_valid", 32'(nvalid - v0), 32'd0);
    check("abort_ferr", 32'(nferr - f0), 32'd0);
    v0 = nvalid;
    send_frame(8'h81, 1'b1, BIT);
    idle(BIT);
    exp_data = 8'h81;
    check("post_rst_valid", 32'(nvalid - v0), 32'd1);
    check("post_rst_data", 32'(data), 32'(exp_data));

    // 2% fast baud.
    v0 = nvalid; f0 = nferr;
    send_frame(8'h5A, 1'b1, 63);
    idle(BIT);
    exp_data = 8'h5A;
    check("fast_valid", 32'(nvalid - v0), 32'd1);
    check("fast_data", 32'(data), 32'(exp_data));
    check("fast_ferr", 32'(nferr - f0), 32'd0);

    // Random bytes, bit periods within +/-3%, occasional bad stop bit.
    for (int k = 0; k < 10; k++) begin
      rb    = 8'($urandom);
      rbclk = $urandom_range(62, 66);
      rstop = ($urandom_range(0, 3) != 0);
      v0 = nvalid; f0 = nferr;
      send_frame(rb, rstop, rbclk);
      if (!rstop) repeat (2 * BIT) @(negedge clk);
      idle($urandom_range(BIT, 3 * BIT));
      if (rstop) exp_data = rb;
      check("rnd_valid", 32'(nvalid - v0), rstop ? 32'd1 : 32'd0);
      check("rnd_ferr", 32'(nferr - f0), rstop ? 32'd0 : 32'd1);
      check("rnd_data", 32'(data), 32'(exp_data));
      check("rnd_busy", 32'(busy), 32'h0);
    end

    check("pulse_overlap", 32'(overlap), 32'd0);
    check("pulse_width", 32'(wide), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
